// File: rtl/rvvi_pkg.sv
// Shared constants and sequence arithmetic for the RVVI reorder receiver.
package rvvi_pkg;

    localparam int SEQ_LSB     = 160;
    localparam int SEQ_BITS    = 64;

    localparam int ACK_SEQ_LSB = 0;
    localparam int ACK_SEQ_MSB = 63;
    localparam int ACK_RSV_LSB = 64;
    localparam int ACK_RSV_MSB = 95;

    // Modular distance from the expected sequence number, truncated to 'bits'.
    function automatic logic [31:0] seq_offset(input logic [31:0] seq,
                                               input logic [31:0] expSeq,
                                               input int bits);
        logic [31:0] mask;
        mask = (32'd1 << bits) - 32'd1;
        return (seq - expSeq) & mask;
    endfunction

endpackage

// File: rtl/rvvi_ack_fifo.sv
// Synchronous FIFO with extra-bit read/write pointers for the outgoing ACK words.
module rvvi_ack_fifo
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 96
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2**DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    // Full when the pointers address the same slot but sit on different laps.
    assign o_full  = (r_wrPtr[DEPTH_LOG2] != r_rdPtr[DEPTH_LOG2]) &&
                     (r_wrPtr[DEPTH_LOG2-1:0] == r_rdPtr[DEPTH_LOG2-1:0]);
    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_data  = r_mem[r_rdPtr[DEPTH_LOG2-1:0]];

    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[DEPTH_LOG2-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/rvvi_reorder_receiver.sv
// Reorder window that restores Minstret order of incoming RVVI packets and
// acknowledges every accepted packet, including stale and duplicate ones.
module rvvi_reorder_receiver
    import rvvi_pkg::*;
#(
    parameter int Entries  = 3,
    parameter int WIDTH    = 792,
    parameter int WIDTH2   = 96,
    parameter int SEQ_LSB  = rvvi_pkg::SEQ_LSB,
    parameter int AckDepth = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              RxValid,
    input  logic [WIDTH-1:0]  RxData,
    output logic              RxReady,
    output logic              OutValid,
    output logic [WIDTH-1:0]  OutData,
    input  logic              OutReady,
    output logic              AckValid,
    output logic [WIDTH2-1:0] AckData,
    input  logic              AckStall,
    output logic [15:0]       DropCount
);

    localparam int SLOTS = 2**Entries;

    logic [WIDTH-1:0]   r_mem [SLOTS];
    logic [SLOTS-1:0]   r_slotValid;
    logic [Entries:0]   r_expSeq;
    logic [15:0]        r_dropCount;

    logic [Entries:0]   w_seq;
    logic [Entries-1:0] w_slotIdx;
    logic [Entries-1:0] w_headIdx;
    logic               w_inWindow;
    logic               w_slotBusy;
    logic               w_accept;
    logic               w_write;
    logic               w_drop;
    logic               w_headValid;
    logic               w_pop;
    logic               w_ackFull;
    logic               w_ackEmpty;
    logic               w_ackPop;
    logic [WIDTH2-1:0]  w_ackWord;

    assign w_seq      = RxData[SEQ_LSB +: Entries+1];
    assign w_slotIdx  = w_seq[Entries-1:0];
    assign w_headIdx  = r_expSeq[Entries-1:0];

    // Anything at or beyond one window ahead of ExpSeq (mod 2*window) was already delivered.
    assign w_inWindow = seq_offset(32'(w_seq), 32'(r_expSeq), Entries + 1) < 32'(SLOTS);
    assign w_slotBusy = r_slotValid[w_slotIdx];

    assign RxReady    = ~w_ackFull;
    assign w_accept   = RxValid & RxReady;
    assign w_write    = w_accept & w_inWindow & ~w_slotBusy;
    assign w_drop     = w_accept & ~w_write;

    // Outputs are masked during reset so nothing leaks out while state is being cleared.
    assign w_headValid = r_slotValid[w_headIdx];
    assign OutValid    = w_headValid & ~reset;
    assign OutData     = r_mem[w_headIdx];
    assign w_pop       = OutValid & OutReady;

    assign AckValid    = ~w_ackEmpty & ~reset;
    assign w_ackPop    = AckValid & ~AckStall;
    assign DropCount   = r_dropCount;

    always_comb begin
        w_ackWord = '0;
        w_ackWord[ACK_SEQ_MSB:ACK_SEQ_LSB] = RxData[SEQ_LSB +: SEQ_BITS];
    end

    // A write never targets the head slot while it is popped: that slot is valid, so it counts as a duplicate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slotValid <= '0;
            r_expSeq    <= '0;
            r_dropCount <= '0;
        end else begin
            if (w_pop) begin
                r_slotValid[w_headIdx] <= 1'b0;
                r_expSeq               <= r_expSeq + (Entries+1)'(1);
            end
            if (w_write) begin
                r_slotValid[w_slotIdx] <= 1'b1;
            end
            if (w_drop && (r_dropCount != 16'hFFFF)) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[w_slotIdx] <= RxData;
        end
    end

    rvvi_ack_fifo #(
        .DEPTH_LOG2 (AckDepth),
        .WIDTH      (WIDTH2)
    ) u_ackFifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  (w_ackWord),
        .i_pop   (w_ackPop),
        .o_data  (AckData),
        .o_full  (w_ackFull),
        .o_empty (w_ackEmpty)
    );

endmodule

// File: tb/tb_rvvi_reorder_receiver.sv
// Randomized bench for rvvi_reorder_receiver against an absolute-sequence reference model.
module tb_rvvi_reorder_receiver;

    localparam int WIDTH    = 792;
    localparam int WIDTH2   = 96;
    localparam int SEQ_LSB  = 160;
    localparam int Entries  = 3;
    localparam int AckDepth = 4;
    localparam int SLOTS    = 8;
    localparam int ACKCAP   = 16;

    typedef enum int {M_INORDER, M_RANDOM, M_PLAN} mode_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              RxValid;
    logic [WIDTH-1:0]  RxData;
    logic              RxReady;
    logic              OutValid;
    logic [WIDTH-1:0]  OutData;
    logic              OutReady;
    logic              AckValid;
    logic [WIDTH2-1:0] AckData;
    logic              AckStall;
    logic [15:0]       DropCount;

    always #5 clk = ~clk;

    rvvi_reorder_receiver #(
        .Entries  (Entries),
        .WIDTH    (WIDTH),
        .WIDTH2   (WIDTH2),
        .SEQ_LSB  (SEQ_LSB),
        .AckDepth (AckDepth)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RxValid   (RxValid),
        .RxData    (RxData),
        .RxReady   (RxReady),
        .OutValid  (OutValid),
        .OutData   (OutData),
        .OutReady  (OutReady),
        .AckValid  (AckValid),
        .AckData   (AckData),
        .AckStall  (AckStall),
        .DropCount (DropCount)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: absolute Minstret numbers, no wrap-around.
    longint           expNext = 0;
    logic [WIDTH-1:0] buffered [longint];
    longint           ackQ [$];
    int               drops = 0;
    longint           sendNext = 0;
    longint           planQ [$];

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] makePkt(input longint m);
        logic [831:0]     raw;
        logic [WIDTH-1:0] pkt;
        for (int i = 0; i < 26; i++) raw[i*32 +: 32] = $urandom;
        pkt = raw[WIDTH-1:0];
        pkt[SEQ_LSB +: 64] = m;
        return pkt;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelEdge(input longint m);
        bit     accept;
        bit     pop;
        bit     ackPop;
        longint off;
        if (reset) begin
            buffered.delete();
            ackQ.delete();
            expNext = 0;
            drops = 0;
            return;
        end
        accept = RxValid && (ackQ.size() < ACKCAP);
        pop    = buffered.exists(expNext) && OutReady;
        ackPop = (ackQ.size() > 0) && !AckStall;
        if (ackPop) void'(ackQ.pop_front());
        if (accept) begin
            off = m - expNext;
            if (off >= 0 && off < SLOTS && !buffered.exists(m))
                buffered[m] = RxData;
            else if (drops < 65535)
                drops++;
            ackQ.push_back(m);
        end
        if (pop) begin
            buffered.delete(expNext);
            expNext++;
        end
    endtask

    task automatic checkCycle();
        bit expOutValid;
        bit expAckValid;
        expOutValid = !reset && buffered.exists(expNext);
        expAckValid = !reset && (ackQ.size() > 0);
        checkOutput("OutValid", WIDTH'(OutValid), WIDTH'(expOutValid));
        if (expOutValid) checkOutput("OutData", OutData, buffered[expNext]);
        checkOutput("AckValid", WIDTH'(AckValid), WIDTH'(expAckValid));
        if (expAckValid) checkOutput("AckData", WIDTH'(AckData), WIDTH'({32'b0, ackQ[0]}));
        if (!reset) begin
            checkOutput("RxReady", WIDTH'(RxReady), WIDTH'(ackQ.size() < ACKCAP));
            checkOutput("DropCount", WIDTH'(DropCount), WIDTH'(16'(drops)));
        end
    endtask

    task automatic applyReset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            reset    = 1'b1;
            RxValid  = 1'b1;
            RxData   = makePkt(longint'($urandom_range(0, 15)));
            OutReady = 1'b1;
            AckStall = 1'b0;
            #1;
            checkCycle();
            modelEdge(0);
        end
    endtask

    task automatic applyStimulus(input mode_t mode, input int cycles,
                                 input int outReadyPct, input int ackStallPct);
        for (int c = 0; c < cycles; c++) begin
            longint m;
            int     r;
            bit     accepted;
            @(negedge clk);
            reset    = 1'b0;
            OutReady = ($urandom_range(0, 99) < outReadyPct);
            AckStall = ($urandom_range(0, 99) < ackStallPct);
            m = expNext;
            case (mode)
                M_INORDER: begin
                    m = sendNext;
                    RxValid = (sendNext - expNext) < SLOTS;
                end
                M_PLAN: begin
                    RxValid = planQ.size() > 0;
                    if (planQ.size() > 0) m = planQ[0];
                end
                default: begin
                    RxValid = ($urandom_range(0, 3) != 0);
                    r = $urandom_range(0, 9);
                    if (r < 2 && expNext > 0)
                        m = expNext - longint'($urandom_range(1, (expNext < 8) ? int'(expNext) : 8));
                    else if (r < 5)
                        m = expNext;
                    else
                        m = expNext + longint'($urandom_range(0, 7));
                end
            endcase
            RxData = makePkt(m);
            #1;
            checkCycle();
            accepted = RxValid && (ackQ.size() < ACKCAP);
            modelEdge(m);
            if (accepted && mode == M_INORDER) sendNext++;
            if (accepted && mode == M_PLAN) void'(planQ.pop_front());
        end
    endtask

    initial begin
        longint base;
        reset    = 1'b1;
        RxValid  = 1'b0;
        RxData   = '0;
        OutReady = 1'b0;
        AckStall = 1'b0;

        applyReset(2);

        sendNext = expNext;
        applyStimulus(M_INORDER, 50, 100, 0);

        applyStimulus(M_RANDOM, 300, 70, 30);

        sendNext = expNext;
        applyStimulus(M_INORDER, 20, 100, 0);

        base = expNext;
        for (int k = 1; k < SLOTS; k++) planQ.push_back(base + k);
        planQ.push_back(base);
        applyStimulus(M_PLAN, 14, 100, 0);

        sendNext = expNext;
        applyStimulus(M_INORDER, 25, 100, 100);
        applyStimulus(M_INORDER, 25, 100, 0);

        applyStimulus(M_RANDOM, 30, 50, 50);
        applyReset(1);
        applyStimulus(M_RANDOM, 150, 70, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
